led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Sequencer for the blink-LED design. Owns a programmable tick divider and steps an LED pattern generator through a configured mode for a configured number of pattern repetitions. Accepts configuration over a valid/ready handshake and start/stop commands from board-level control logic, and drives the LED pins directly.

## Interface
Parameters:
- DIV_W, 24: width of the tick divisor.
- LED_W, 4: number of LEDs; legal range 2..8.
- DEFAULT_DIV, 24'd12_000_000: divisor loaded at reset.

Ports:
- clk_i  in  1  single system clock.
- rst_i  in  1  reset; synchronous, active-high.
- cfg_valid_i  in  1  configuration offered.
- cfg_ready_o  out  1  configuration accepted this cycle when high with cfg_valid_i.
- cfg_div_i  in  DIV_W  clk_i cycles per step; 0 is treated as 1.
- cfg_mode_i  in  2  0 blink, 1 walk, 2 bounce, 3 count.
- cfg_reps_i  in  8  pattern repetitions; 0 means run until stop.
- start_i  in  1  begin a run (level sampled).
- stop_i  in  1  abort a run.
- busy_o  out  1  high while running.
- done_o  out  1  one-cycle pulse on normal completion.
- tick_o  out  1  step strobe, high in the cycle a step is taken.
- led_o  out  LED_W  pattern output.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on start_i.
  - RUN to IDLE on stop_i; no done pulse.
  - RUN to DONE on the tick that completes repetition cfg_reps.
  - DONE to IDLE unconditionally after one cycle.
- cfg_ready_o = 1 in IDLE only. Registers div/mode/reps load on valid&&ready. cfg_valid_i in RUN or DONE stalls; no drop, no overwrite.
- If cfg accept and start_i coincide in IDLE, the run uses the newly accepted values.
- start_i in RUN or DONE is ignored.
- Tick counter:
  - Cleared on entry to RUN. Increments each RUN cycle.
  - tick_o = RUN && cnt == div_eff-1, where div_eff = max(div,1). Counter wraps to 0 on tick.
- Initial pattern on entering RUN: blink all-ones; walk and bounce 1; count 0.
- Step on each tick:
  - Blink: invert all bits. Cycle length 2.
  - Walk: rotate left by 1. Cycle length LED_W.
  - Bounce: shift left until MSB set, then right until LSB set. Cycle length 2*LED_W-2.
  - Count: increment modulo 2^LED_W. Cycle length 2^LED_W.
- Step counter counts steps within a cycle. Repetition counter (8 bit) increments when a cycle completes, which is when the pattern returns to its initial value.
- Completion: reps != 0 and the tick completes cycle number reps. reps = 0 never completes.
- led_o = 0 in IDLE and DONE.
- busy_o = (state == RUN).
- done_o = (state == DONE).
- Reset (any state, mid-run included):
  - State IDLE. All counters 0.
  - div = DEFAULT_DIV, mode = 0, reps = 0.
  - Outputs: led_o = 0, busy_o = 0, done_o = 0, tick_o = 0, cfg_ready_o = 1 from the first cycle after reset.
- stop_i and a completion tick in the same cycle: stop wins. Go to IDLE, no done pulse.

## Timing
- start_i sampled at edge N: busy_o = 1 and the initial pattern on led_o from cycle N+1.
- First tick_o in cycle N+div_eff. The new pattern is visible from the next cycle.
- Steady state: one step every div_eff cycles. div_eff = 1 gives a tick in every RUN cycle.
- Completion tick in cycle T: done_o = 1, busy_o = 0, led_o = 0 in T+1. IDLE and cfg_ready_o = 1 in T+2.
- stop_i at edge S: IDLE from S+1, with led_o = 0 and cfg_ready_o = 1.
- All outputs registered except tick_o and cfg_ready_o, which decode from registered state.

## Structure
- Package led_pkg holds:
  - the mode encoding localparams (MODE_BLINK, MODE_WALK, MODE_BOUNCE, MODE_COUNT),
  - the FSM state encoding,
  - a function returning cycle length per mode and LED_W.
- Sub-module led_tick_gen: programmable divider with inputs clk_i, rst_i, clear, en, div and output tick. The top holds the FSM, config registers, pattern and repetition logic.

## Test plan
- Reset mid-run: assert rst_i in a RUN cycle. Next cycle: led_o = 0, busy_o = 0, cfg_ready_o = 1. A subsequent start uses div = DEFAULT_DIV.
- Walk, LED_W = 4, div = 3, reps = 1, start at cycle 0:
  - led_o 0001 at cycle 1, 0010 at 4, 0100 at 7, 1000 at 10.
  - tick_o at cycles 3, 6, 9, 12.
  - done_o at 13 with led_o = 0. cfg_ready_o at 14.
- Bounce, div = 0, reps = 2: led_o goes 0001, 0010, 0100, 1000, 0100, 0010, twice, one step per cycle. done_o one cycle after the 12th tick.
- Blink, reps = 0, div = 2: led_o alternates 1111/0000 every 2 cycles indefinitely. stop_i at cycle 20 gives IDLE and led_o = 0 at 21, with no done_o.
- Handshake:
  - cfg_valid_i held during RUN: cfg_ready_o stays 0 and the config is unchanged. It is accepted in the first IDLE cycle.
  - cfg and start in the same IDLE cycle: the run uses the new mode.
- stop_i coincident with the completion tick: IDLE next cycle, done_o stays 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern sequencer: pattern modes, FSM states,
// and the number of steps each mode takes to return to its initial pattern.
package led_pkg;

    localparam logic [1:0] MODE_BLINK  = 2'd0;
    localparam logic [1:0] MODE_WALK   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Steps per pattern cycle; 9 bits covers count mode at LED_W = 8 (256).
    function automatic logic [8:0] cycle_len(input logic [1:0] mode, input int unsigned led_w);
        logic [8:0] len;
        case (mode)
            MODE_BLINK:  len = 9'd2;
            MODE_WALK:   len = 9'(led_w);
            MODE_BOUNCE: len = 9'(2 * led_w - 2);
            default:     len = 9'(1 << led_w);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Programmable step divider: strobes tick once every max(div,1) enabled cycles,
// counting from zero after clear.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d, div_eff;

    always_comb begin
        div_eff = (div == '0) ? ONE : div;
        tick    = en && (cnt_q == div_eff - ONE);
        cnt_d   = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED sequencer: accepts config while idle, runs the selected pattern for the
// configured number of cycles (0 = forever) and pulses done on completion.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int               DIV_W       = 24,
    parameter int               LED_W       = 4,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(12_000_000)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic [7:0]       cfg_reps_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             tick_o,
    output logic [LED_W-1:0] led_o
);

    localparam logic [LED_W-1:0] PAT_ONE     = LED_W'(1);
    localparam logic [8:0]       BOUNCE_TURN = 9'(LED_W - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       reps_q, reps_d;
    logic [LED_W-1:0] pat_q, pat_d, pat_next, pat_init;
    logic [8:0]       step_q, step_d;
    logic [7:0]       rep_q, rep_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             tick, clear, last_step;

    led_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (clear),
        .en    (state_q == ST_RUN),
        .div   (div_q),
        .tick  (tick)
    );

    assign cfg_ready_o = (state_q == ST_IDLE);
    assign tick_o      = tick;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign led_o       = pat_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        mode_d    = mode_q;
        reps_d    = reps_q;
        pat_d     = pat_q;
        step_d    = step_q;
        rep_d     = rep_q;
        clear     = 1'b0;
        last_step = (step_q + 9'd1) == cycle_len(mode_q, LED_W);

        case (mode_q)
            MODE_BLINK:  pat_next = ~pat_q;
            MODE_WALK:   pat_next = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            MODE_BOUNCE: pat_next = (step_q < BOUNCE_TURN) ? (pat_q << 1) : (pat_q >> 1);
            default:     pat_next = pat_q + PAT_ONE;
        endcase

        if (cfg_valid_i && cfg_ready_o) begin
            div_d  = cfg_div_i;
            mode_d = cfg_mode_i;
            reps_d = cfg_reps_i;
        end

        // Seed from mode_d so a config accepted alongside start takes effect.
        case (mode_d)
            MODE_BLINK: pat_init = '1;
            MODE_COUNT: pat_init = '0;
            default:    pat_init = PAT_ONE;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                    pat_d   = pat_init;
                    step_d  = '0;
                    rep_d   = '0;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    pat_d   = '0;
                end else if (tick) begin
                    pat_d  = pat_next;
                    step_d = step_q + 9'd1;
                    if (last_step) begin
                        step_d = '0;
                        rep_d  = rep_q + 8'd1;
                        if (reps_q != '0 && (rep_q + 8'd1) == reps_q) begin
                            state_d = ST_DONE;
                            pat_d   = '0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= DEFAULT_DIV;
            mode_q  <= MODE_BLINK;
            reps_q  <= '0;
            pat_q   <= '0;
            step_q  <= '0;
            rep_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            reps_q  <= reps_d;
            pat_q   <= pat_d;
            step_q  <= step_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus random traffic, every
// cycle compared against a timeline model of the sequencer.
module tb_led_pattern_ctrl;

    localparam int               DIV_W   = 24;
    localparam int               LED_W   = 4;
    localparam logic [DIV_W-1:0] DEF_DIV = 24'd5;

    logic             clk = 1'b0;
    logic             rst_i, cfg_valid_i, cfg_ready_o, start_i, stop_i;
    logic [DIV_W-1:0] cfg_div_i;
    logic [1:0]       cfg_mode_i;
    logic [7:0]       cfg_reps_i;
    logic             busy_o, done_o, tick_o;
    logic [LED_W-1:0] led_o;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.DIV_W(DIV_W), .LED_W(LED_W), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_div_i   (cfg_div_i),
        .cfg_mode_i  (cfg_mode_i),
        .cfg_reps_i  (cfg_reps_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tick_o      (tick_o),
        .led_o       (led_o)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: 0 idle, 1 run, 2 done; m_c counts cycles since entering run.
    int m_st = 0, m_c = 0, m_div = 0, m_mode = 0, m_reps = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cyc_len(input int mode);
        case (mode)
            0:       return 2;
            1:       return LED_W;
            2:       return 2 * LED_W - 2;
            default: return 1 << LED_W;
        endcase
    endfunction

    // Pattern after k steps, straight from the mode definitions.
    function automatic int exp_pat(input int mode, input int k);
        int p;
        case (mode)
            0: return (k % 2 == 0) ? (1 << LED_W) - 1 : 0;
            1: return 1 << (k % LED_W);
            2: begin
                p = k % (2 * LED_W - 2);
                return (p < LED_W) ? (1 << p) : (1 << (2 * LED_W - 2 - p));
            end
            default: return k % (1 << LED_W);
        endcase
    endfunction

    task automatic step(input bit rst, input bit cv, input int div, input int mode,
                        input int reps, input bit st, input bit sp);
        int d;
        bit tk;
        @(negedge clk);
        d  = (m_div == 0) ? 1 : m_div;
        tk = (m_st == 1) && ((m_c + 1) % d == 0);
        if (chk_en) begin
            chk("busy",  32'(busy_o),      32'(m_st == 1));
            chk("done",  32'(done_o),      32'(m_st == 2));
            chk("ready", 32'(cfg_ready_o), 32'(m_st == 0));
            chk("tick",  32'(tick_o),      32'(tk));
            chk("led",   32'(led_o),       (m_st == 1) ? exp_pat(m_mode, m_c / d) : 0);
        end
        rst_i       = rst;
        cfg_valid_i = cv;
        cfg_div_i   = DIV_W'(div);
        cfg_mode_i  = 2'(mode);
        cfg_reps_i  = 8'(reps);
        start_i     = st;
        stop_i      = sp;
        if (rst) begin
            m_st = 0; m_c = 0; m_div = int'(DEF_DIV); m_mode = 0; m_reps = 0;
        end else begin
            case (m_st)
                0: begin
                    if (cv) begin m_div = div; m_mode = mode; m_reps = reps; end
                    if (st) begin m_st = 1; m_c = 0; end
                end
                1: begin
                    if (sp) m_st = 0;
                    else if (tk && m_reps != 0 && m_c / d + 1 == m_reps * cyc_len(m_mode)) m_st = 2;
                    else m_c++;
                end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        idle(2);

        // Walk div 3 reps 1, config accepted together with start.
        step(0, 1, 3, 1, 1, 1, 0);
        idle(16);

        // Bounce with div 0 (one step per cycle), two repetitions.
        step(0, 1, 0, 2, 2, 1, 0);
        idle(16);

        // Blink forever at div 2, stopped after 20 cycles.
        step(0, 1, 2, 0, 0, 1, 0);
        idle(19);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Config held through a walk run stalls until idle, then is used.
        step(0, 1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 3, 3, 2, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(10);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Stop coincident with the completion tick.
        step(0, 1, 1, 1, 1, 1, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Reset mid-run; the following start falls back to the default divisor.
        step(0, 1, 1, 2, 0, 1, 0);
        idle(5);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(14);
        step(0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 79) == 0);
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
